// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its requester arbiter: funct codes,
// arbiter state encoding and the supported-funct predicate.
package alu_pkg;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;

  function automatic bit funct_supported(input logic [5:0] funct);
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR,
      FN_NOR, FN_SLT, FN_SLL, FN_SRL: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. Unsupported funct codes drive y to X; callers
// must qualify the result with funct_supported().
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [5:0]  funct,
  output logic [31:0] y,
  output logic        zero
);

  always_comb begin
    y = 'x;
    case (funct)
      FN_ADD: y = a + b;
      FN_SUB: y = a - b;
      FN_AND: y = a & b;
      FN_OR:  y = a | b;
      FN_XOR: y = a ^ b;
      FN_NOR: y = ~(a | b);
      FN_SLT: y = {31'b0, (a < b)};
      FN_SLL: y = a << b;
      FN_SRL: y = a >> b;
      default: y = 'x;
    endcase
    zero = (y == 32'd0);
  end

endmodule

// File: rtl/rr_pick.sv
// Round-robin priority picker: first valid index at or after ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0] grant_idx
);

  logic found;
  int   k;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (int'(ptr) + i) % N_REQ;
      if (!found && valid[k]) begin
        found       = 1'b1;
        grant_oh[k] = 1'b1;
        grant_idx   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU among N_REQ requesters: round-robin accept, one cycle of
// evaluation from latched operands, response held until the owner takes it.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int W     = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  output logic [N_REQ-1:0]   req_ready_o,
  input  logic [N_REQ*W-1:0] req_a_i,
  input  logic [N_REQ*W-1:0] req_b_i,
  input  logic [N_REQ*6-1:0] req_funct_i,
  output logic [N_REQ-1:0]   rsp_valid_o,
  input  logic [N_REQ-1:0]   rsp_ready_i,
  output logic [W-1:0]       rsp_y_o32,
  output logic               rsp_zero_o,
  output logic               rsp_err_o,
  output logic               busy_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_oh;
  logic             accept;

  logic [W-1:0]     a_p0;
  logic [W-1:0]     b_p0;
  logic [5:0]       funct_p0;
  logic [W-1:0]     alu_y;
  logic             alu_zero;
  logic             err_p0;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .valid     (req_valid_i),
    .ptr       (rr_ptr),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx)
  );

  assign req_ready_o = (state == IDLE) ? pick_oh : '0;
  assign accept      = |(req_valid_i & req_ready_o);
  assign busy_o      = (state != IDLE);

  always_comb begin
    rsp_valid_o = '0;
    if (state == RESP) rsp_valid_o[grant] = 1'b1;
  end

  // Stage p0: operands latched at accept, held through EXEC
  always_ff @(posedge clk_i) begin
    if (accept) begin
      a_p0     <= req_a_i[pick_idx*W +: W];
      b_p0     <= req_b_i[pick_idx*W +: W];
      funct_p0 <= req_funct_i[pick_idx*6 +: 6];
    end
  end

  alu u_alu (
    .a     (a_p0),
    .b     (b_p0),
    .funct (funct_p0),
    .y     (alu_y),
    .zero  (alu_zero)
  );

  assign err_p0 = !funct_supported(funct_p0);

  // Stage p1: response registers; an unsupported funct never lets X through
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      rsp_y_o32  <= '0;
      rsp_zero_o <= 1'b0;
      rsp_err_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            grant <= pick_idx;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_y_o32  <= err_p0 ? '0 : alu_y;
          rsp_zero_o <= err_p0 | alu_zero;
          rsp_err_o  <= err_p0;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready_i[grant]) begin
            rr_ptr <= (grant == IDX_W'(N_REQ-1)) ? '0 : grant + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb with two requesters.
module tb_alu_share_arb;
  import alu_pkg::*;

  localparam int N = 2;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             rst_i;
  logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0]   req_a, req_b;
  logic [N*6-1:0]   req_f;
  logic [W-1:0]     rsp_y;
  logic             rsp_zero, rsp_err, busy;

  logic             rv [N];
  logic [W-1:0]     ra [N];
  logic [W-1:0]     rb [N];
  logic [5:0]       rf [N];

  assign req_valid = {rv[1], rv[0]};
  assign req_a     = {ra[1], ra[0]};
  assign req_b     = {rb[1], rb[0]};
  assign req_f     = {rf[1], rf[0]};

  alu_share_arb #(.N_REQ(N), .W(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_funct_i (req_f),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_y_o32   (rsp_y),
    .rsp_zero_o  (rsp_zero),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          req;
    logic [31:0] y;
    logic        z;
    logic        e;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   gq[$];
  int   n_tot = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic [N-1:0] vprev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                                output logic [31:0] y, output logic z, output logic e);
    e = 1'b0;
    case (f)
      6'h20: y = a + b;
      6'h22: y = a - b;
      6'h24: y = a & b;
      6'h25: y = a | b;
      6'h26: y = a ^ b;
      6'h27: y = ~(a | b);
      6'h2A: y = (a < b) ? 32'd1 : 32'd0;
      6'h00: y = (b >= 32) ? 32'd0 : (a << b[4:0]);
      6'h02: y = (b >= 32) ? 32'd0 : (a >> b[4:0]);
      default: begin y = 32'd0; e = 1'b1; end
    endcase
    z = (y == 32'd0);
  endfunction

  always @(negedge clk) begin
    if (rst_i) begin
      sb.delete();
      vprev = '0;
    end else begin
      if (req_ready != '0) chk("ready_onehot", 64'($onehot(req_ready)), 64'd1);
      for (int k = 0; k < N; k++) begin
        if (rv[k] && req_ready[k]) begin
          exp_t x;
          model(ra[k], rb[k], rf[k], x.y, x.z, x.e);
          x.req = k;
          x.acc = cyc;
          sb.push_back(x);
          gq.push_back(k);
        end
      end
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          if (vprev == '0) chk("latency", 64'(cyc - sb[0].acc), 64'd2);
          if ((rsp_valid & rsp_ready) != '0) begin
            exp_t x;
            x = sb.pop_front();
            chk("rsp_who",  64'(rsp_valid), 64'd1 << x.req);
            chk("rsp_y",    64'(rsp_y),     64'(x.y));
            chk("rsp_zero", 64'(rsp_zero),  64'(x.z));
            chk("rsp_err",  64'(rsp_err),   64'(x.e));
          end
        end
      end
      vprev = rsp_valid;
    end
  end

  task automatic send(input int k, input logic [31:0] a, input logic [31:0] b,
                      input logic [5:0] f, output int waits);
    ra[k] = a;
    rb[k] = b;
    rf[k] = f;
    rv[k] = 1'b1;
    waits = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req_ready[k]) begin
        waits = i;
        break;
      end
    end
    if (waits < 0) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 rv[k] = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("drain_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_i     = 1'b1;
    rsp_ready = 2'b11;
    for (int k = 0; k < N; k++) begin
      rv[k] = 1'b0; ra[k] = '0; rb[k] = '0; rf[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready),  64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid),  64'd0);
    chk("rst_y",         64'(rsp_y),      64'd0);
    chk("rst_zero",      64'(rsp_zero),   64'd0);
    chk("rst_err",       64'(rsp_err),    64'd0);
    chk("rst_busy",      64'(busy),       64'd0);
    chk("rst_ptr",       64'(dut.rr_ptr), 64'd0);
    @(posedge clk);
    #1 rst_i = 1'b0;

    send(0, 32'd5, 32'd7, FN_ADD, w); drain();
    send(1, 32'd9, 32'd9, FN_SUB, w); drain();

    gq.delete();
    fork
      begin
        int w0;
        repeat (3) send(0, 32'hF0F0, 32'hFF00, FN_AND, w0);
      end
      begin
        int w1;
        repeat (3) send(1, 32'hF0F0, 32'hFF00, FN_OR, w1);
      end
    join
    drain();
    chk("fair_count", 64'(gq.size()), 64'd6);
    for (int i = 0; i < gq.size(); i++) chk("fair_order", 64'(gq[i]), 64'(i % 2));

    rsp_ready = 2'b00;
    send(0, 32'd100, 32'd23, FN_SUB, w);
    ra[1] = 32'd3; rb[1] = 32'd4; rf[1] = FN_XOR; rv[1] = 1'b1;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_y",     64'(rsp_y),     64'd77);
      chk("bp_zero",  64'(rsp_zero),  64'd0);
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_busy",  64'(busy),      64'd1);
    end
    @(posedge clk);
    #1 rsp_ready = 2'b11;
    fork
      send(1, 32'd3, 32'd4, FN_XOR, w);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("bp_release", 64'(rsp_valid), 64'd0);
      end
    join
    drain();

    send(0, 32'd1, 32'd2, 6'h18, w);              drain();
    send(1, 32'd1, 32'd4, FN_SLL, w);             drain();
    send(0, 32'h8000_0000, 32'd31, FN_SRL, w);    drain();
    send(1, 32'hFFFF_FFFF, 32'd1, FN_ADD, w);     drain();
    send(0, 32'hFFFF_FFFF, 32'd1, FN_SLT, w);     drain();
    send(1, 32'd5, 32'd40, FN_SLL, w);            drain();
    send(0, 32'h0F0F_0000, 32'h0000_00FF, FN_NOR, w); drain();
    chk("ptr_before_rst", 64'(dut.rr_ptr), 64'd1);

    send(0, 32'd1, 32'd1, FN_ADD, w);
    rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy",  64'(busy),       64'd0);
    chk("rst_mid_valid", 64'(rsp_valid),  64'd0);
    chk("rst_mid_ptr",   64'(dut.rr_ptr), 64'd0);
    @(posedge clk);
    #1;
    send(1, 32'd2, 32'd3, FN_ADD, w);
    chk("rst_fresh_wait", 64'(w), 64'd0);
    drain();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
